// File: rtl/la_fifo_push_arb.sv
// rtl/la_fifo_push_arb.sv - round-robin, packet-aware push arbiter for one shared FIFO write port
// Optional perf counters are enabled by defining LA_FIFO_ARB_PERF_EN.
module la_fifo_push_arb #(
  parameter int  N_REQ      = 4,
  parameter int  DATA_WIDTH = 32,
  parameter type dtype      = logic [DATA_WIDTH-1:0],
  parameter int  MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [N_REQ-1:0]  req_valid_i,
  input  dtype              req_data_i [N_REQ],
  input  logic [N_REQ-1:0]  req_last_i,
  output logic [N_REQ-1:0]  req_ready_o,
  output logic [N_REQ-1:0]  grant_o,
  input  logic              fifo_full_i,
  output logic              fifo_push_o,
  output dtype              fifo_data_o,
  output logic              fifo_flush_o,
  output logic              busy_o,
  output logic [31:0]       perf_grant_cnt_o [N_REQ],
  output logic [31:0]       perf_stall_cnt_o
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int BCW   = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0]   lock_id, lock_id_n;
  logic [BCW-1:0]     beat_cnt, beat_cnt_n;

  logic [PTR_W-1:0]   cand_id;
  logic               cand_found;
  logic [PTR_W-1:0]   owner;
  logic               has_grant;
  logic               accept;
  logic               cap_hit;
  logic               end_grant;

  // Cyclic scan starting at rr_ptr; N_REQ need not be a power of two.
  always_comb begin : scan
    int idx;
    idx        = 0;
    cand_found = 1'b0;
    cand_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!cand_found && req_valid_i[idx]) begin
        cand_found = 1'b1;
        cand_id    = PTR_W'(idx);
      end
    end
  end

  assign owner     = (state == LOCKED) ? lock_id : cand_id;
  assign has_grant = rst_n && ((state == LOCKED) || cand_found);
  assign accept    = has_grant && req_valid_i[owner] && !fifo_full_i && !flush_i;
  assign cap_hit   = (MAX_BURST != 0) && ((int'(beat_cnt) + 1) == MAX_BURST);
  assign end_grant = req_last_i[owner] || cap_hit;

  always_comb begin
    grant_o            = '0;
    grant_o[owner]     = has_grant;
    req_ready_o        = '0;
    req_ready_o[owner] = accept;
  end

  assign fifo_push_o  = accept;
  assign fifo_data_o  = has_grant ? req_data_i[owner] : req_data_i[0];
  assign fifo_flush_o = rst_n && flush_i;
  assign busy_o       = rst_n && (state == LOCKED);

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    lock_id_n  = lock_id;
    beat_cnt_n = beat_cnt;
    if (flush_i) begin
      state_n    = IDLE;
      beat_cnt_n = '0;
    end else if (accept) begin
      if (end_grant) begin
        state_n    = IDLE;
        beat_cnt_n = '0;
        rr_ptr_n   = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
      end else begin
        state_n    = LOCKED;
        lock_id_n  = owner;
        beat_cnt_n = beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_id  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      lock_id  <= lock_id_n;
      beat_cnt <= beat_cnt_n;
    end
  end

`ifdef LA_FIFO_ARB_PERF_EN
  logic [31:0] grant_cnt [N_REQ];
  logic [31:0] stall_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && (int'(owner) == i)) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if ((|req_valid_i) && fifo_full_i && !flush_i) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_grant_cnt_o = grant_cnt;
  assign perf_stall_cnt_o = stall_cnt;
`else
  always_comb begin
    for (int i = 0; i < N_REQ; i++) perf_grant_cnt_o[i] = '0;
  end
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_la_fifo_push_arb.sv
// tb/tb_la_fifo_push_arb.sv - directed table, corner sequences and random model check of la_fifo_push_arb
module tb_la_fifo_push_arb;
  localparam int N  = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i [N];
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic        fifo_full_i;
  logic        fifo_push_o;
  logic [31:0] fifo_data_o;
  logic        fifo_flush_o;
  logic        busy_o;
  logic [31:0] perf_grant_cnt_o [N];
  logic [31:0] perf_stall_cnt_o;

  la_fifo_push_arb #(.N_REQ(N), .DATA_WIDTH(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .fifo_full_i(fifo_full_i),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o), .fifo_flush_o(fifo_flush_o),
    .busy_o(busy_o), .perf_grant_cnt_o(perf_grant_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v, l;
    logic       f, fl;
    logic [3:0] g, r;
    logic       p, fo, b;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add(logic [3:0] v, l, logic f, fl, logic [3:0] g, r, logic p, fo, b);
    vec_t t;
    t.v = v; t.l = l; t.f = f; t.fl = fl; t.g = g; t.r = r; t.p = p; t.fo = fo; t.b = b;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic rs, input logic [3:0] v, l, input logic f, fl);
    @(negedge clk);
    rst_n = rs; req_valid_i = v; req_last_i = l; fifo_full_i = f; flush_i = fl;
    #2;
  endtask

  function automatic int onehot_idx(logic [3:0] x);
    for (int i = 0; i < N; i++) if (x[i]) return i;
    return 0;
  endfunction

  // Reference model state: owner < 0 means nobody holds the grant.
  int m_owner, m_beats, m_ptr;
  int m_gcnt [N];
  int m_stall;

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endfunction

  int exp_g [N];
  int exp_stall;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = '0; req_last_i = '0; fifo_full_i = 1'b0;
    for (int i = 0; i < N; i++) req_data_i[i] = 32'hA000_0000 | i;

    for (int i = 0; i < 8; i++) add(4'hF, 4'hF, 0, 0, 4'(1 << (i % 4)), 4'(1 << (i % 4)), 1, 0, 0);
    add(4'h6, 4'h0, 0, 0, 4'h2, 4'h2, 1, 0, 0);
    add(4'h6, 4'h0, 0, 0, 4'h2, 4'h2, 1, 0, 1);
    add(4'h6, 4'h2, 0, 0, 4'h2, 4'h2, 1, 0, 1);
    add(4'h4, 4'h4, 0, 0, 4'h4, 4'h4, 1, 0, 0);
    add(4'h8, 4'h8, 0, 0, 4'h8, 4'h8, 1, 0, 0);
    add(4'h9, 4'h8, 0, 0, 4'h1, 4'h1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(4'h9, 4'h8, 0, 0, 4'h1, 4'h1, 1, 0, 1);
    add(4'h9, 4'h8, 0, 0, 4'h8, 4'h8, 1, 0, 0);
    add(4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 1, 0, 0);
    add(4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(4'h1, 4'h0, 1, 0, 4'h1, 4'h0, 0, 0, 1);
    add(4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 1, 0, 1);
    add(4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 1, 0, 1);
    add(4'h3, 4'h3, 0, 0, 4'h2, 4'h2, 1, 0, 0);
    add(4'h4, 4'h0, 0, 0, 4'h4, 4'h4, 1, 0, 0);
    add(4'h6, 4'h0, 0, 1, 4'h4, 4'h0, 0, 1, 1);
    add(4'h6, 4'h4, 0, 0, 4'h4, 4'h4, 1, 0, 0);
    add(4'h8, 4'h0, 0, 0, 4'h8, 4'h8, 1, 0, 0);
    add(4'h1, 4'h0, 0, 0, 4'h8, 4'h0, 0, 0, 1);
    add(4'h8, 4'h8, 0, 0, 4'h8, 4'h8, 1, 0, 1);
    add(4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_push", 32'(fifo_push_o), 0);
    chk("rst_flush", 32'(fifo_flush_o), 0);
    chk("rst_busy", 32'(busy_o), 0);

    for (int i = 0; i < N; i++) exp_g[i] = 0;
    exp_stall = 0;
    foreach (tbl[k]) begin
      drive(1'b1, tbl[k].v, tbl[k].l, tbl[k].f, tbl[k].fl);
      chk($sformatf("t%0d_grant", k), 32'(grant_o), 32'(tbl[k].g));
      chk($sformatf("t%0d_ready", k), 32'(req_ready_o), 32'(tbl[k].r));
      chk($sformatf("t%0d_push", k), 32'(fifo_push_o), 32'(tbl[k].p));
      chk($sformatf("t%0d_flush", k), 32'(fifo_flush_o), 32'(tbl[k].fo));
      chk($sformatf("t%0d_busy", k), 32'(busy_o), 32'(tbl[k].b));
      if (tbl[k].p) chk($sformatf("t%0d_data", k), fifo_data_o, 32'hA000_0000 | onehot_idx(tbl[k].r));
      if (tbl[k].r != 0) exp_g[onehot_idx(tbl[k].r)]++;
      if (tbl[k].v != 0 && tbl[k].f && !tbl[k].fl) exp_stall++;
    end

    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef LA_FIFO_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk($sformatf("perf_grant%0d", i), perf_grant_cnt_o[i], 32'(exp_g[i]));
    chk("perf_stall", perf_stall_cnt_o, 32'(exp_stall));
`else
    for (int i = 0; i < N; i++) chk($sformatf("perf_grant%0d", i), perf_grant_cnt_o[i], 0);
    chk("perf_stall", perf_stall_cnt_o, 0);
`endif

    // Reset while producer 1 holds a packet: priority must restart at producer 0.
    drive(1'b1, 4'h2, 4'h0, 1'b0, 1'b0);
    chk("rm_grant_pre", 32'(grant_o), 32'h2);
    drive(1'b1, 4'h2, 4'h0, 1'b0, 1'b0);
    chk("rm_busy_pre", 32'(busy_o), 1);
    drive(1'b0, 4'h2, 4'h0, 1'b0, 1'b1);
    chk("rm_grant", 32'(grant_o), 0);
    chk("rm_ready", 32'(req_ready_o), 0);
    chk("rm_push", 32'(fifo_push_o), 0);
    chk("rm_flush", 32'(fifo_flush_o), 0);
    chk("rm_busy", 32'(busy_o), 0);
    drive(1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
    chk("rm_after_grant", 32'(grant_o), 32'h1);
    chk("rm_after_busy", 32'(busy_o), 0);
    chk("rm_perf_stall_clr", perf_stall_cnt_o, 0);
    chk("rm_perf_g1_clr", perf_grant_cnt_o[1], 0);

    // Randomized run against the reference model.
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] v, l;
      logic f, fl, acc;
      int g;
      v  = 4'($urandom);
      l  = 4'($urandom) & 4'($urandom);
      f  = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) req_data_i[i] = $urandom;
      rst_n = 1'b1; req_valid_i = v; req_last_i = l; fifo_full_i = f; flush_i = fl;
      #2;
      if (m_owner >= 0) g = m_owner;
      else begin
        g = -1;
        for (int k = 0; k < N; k++) if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      acc = (g >= 0) && v[g] && !f && !fl;
      chk("rnd_grant", 32'(grant_o), (g >= 0) ? (32'd1 << g) : 0);
      chk("rnd_ready", 32'(req_ready_o), acc ? (32'd1 << g) : 0);
      chk("rnd_push", 32'(fifo_push_o), 32'(acc));
      chk("rnd_flush", 32'(fifo_flush_o), 32'(fl));
      chk("rnd_busy", 32'(busy_o), 32'(m_owner >= 0));
      if (acc) chk("rnd_data", fifo_data_o, req_data_i[g]);
      if (acc) m_gcnt[g]++;
      if (v != 0 && f && !fl) m_stall++;
      if (fl) begin
        m_owner = -1; m_beats = 0;
      end else if (acc) begin
        m_beats++;
        if (l[g] || m_beats == MB) begin
          m_owner = -1; m_beats = 0; m_ptr = (g + 1) % N;
        end else m_owner = g;
      end
    end
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef LA_FIFO_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk($sformatf("rnd_perf_grant%0d", i), perf_grant_cnt_o[i], 32'(m_gcnt[i]));
    chk("rnd_perf_stall", perf_stall_cnt_o, 32'(m_stall));
`else
    for (int i = 0; i < N; i++) chk($sformatf("rnd_perf_grant%0d", i), perf_grant_cnt_o[i], 0);
    chk("rnd_perf_stall", perf_stall_cnt_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
